// File: rtl/mod_dec_invaddroundkey_seq.sv
// AES-256 inverse-cipher AddRoundKey stage: XORs a captured state with round keys fetched downward NR..0.
// Optional key parity checking is enabled by defining DEC_ADDRK_KEYPAR_EN.
module mod_dec_invaddroundkey_seq #(
  parameter int NR      = 14,
  parameter int KEY_LAT = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] inp_addRK,
  output logic [3:0]   key_addr,
  input  logic [127:0] inp_key,
`ifdef DEC_ADDRK_KEYPAR_EN
  input  logic [15:0]  key_par,
  output logic         key_err,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] outp_addRK,
  output logic [3:0]   out_round,
  output logic         out_last
);

  // state | meaning
  // IDLE  | ready for a block; start reloads the round index
  // FETCH | key_addr issued, counting down the key read latency
  // HOLD  | result presented, waiting for out_ready
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  localparam logic [3:0] NR_IDX  = 4'(NR);
  localparam logic [1:0] LAT_CNT = 2'(KEY_LAT);

  state_t       state_q, state_d;
  logic [3:0]   round_q;
  logic [3:0]   round_nxt;
  logic [1:0]   lat_cnt;
  logic [127:0] data_q;
  logic         accept, fire, done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    accept   = 1'b0;
    fire     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (lat_cnt == 2'd0) begin
          fire    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign round_nxt = (round_q == 4'd0) ? NR_IDX : round_q - 4'd1;

  // The counter covers the key_addr register stage plus the ROM latency,
  // so the key is sampled KEY_LAT+1 edges after the accept edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      round_q    <= NR_IDX;
      key_addr   <= NR_IDX;
      lat_cnt    <= 2'd0;
      data_q     <= '0;
      out_valid  <= 1'b0;
      outp_addRK <= '0;
      out_round  <= 4'd0;
      out_last   <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        round_q  <= NR_IDX;
        key_addr <= NR_IDX;
      end
      if (accept) begin
        data_q   <= inp_addRK;
        key_addr <= start ? NR_IDX : round_q;
        lat_cnt  <= LAT_CNT;
      end
      if (state_q == FETCH && lat_cnt != 2'd0) lat_cnt <= lat_cnt - 2'd1;
      if (fire) begin
        outp_addRK <= data_q ^ inp_key;
        out_round  <= key_addr;
        out_last   <= (key_addr == 4'd0);
        out_valid  <= 1'b1;
      end
      if (done) begin
        out_valid <= 1'b0;
        round_q   <= round_nxt;
        key_addr  <= round_nxt;
      end
    end
  end

`ifdef DEC_ADDRK_KEYPAR_EN
  logic [15:0] par_calc;

  always_comb begin
    par_calc = '0;
    for (int b = 0; b < 16; b++) par_calc[b] = ^inp_key[8*b +: 8];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                         key_err <= 1'b0;
    else if (state_q == IDLE && start)   key_err <= 1'b0;
    else if (fire && key_par != par_calc) key_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mod_dec_invaddroundkey_seq.sv
// Directed bench for mod_dec_invaddroundkey_seq with a registered key ROM model (KEY_LAT=1).
module tb_mod_dec_invaddroundkey_seq;
  logic         clk = 1'b0;
  logic         resetn, start, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [127:0] inp_addRK, inp_key, outp_addRK;
  logic [3:0]   key_addr, out_round;
`ifdef DEC_ADDRK_KEYPAR_EN
  logic [15:0]  key_par, par_flip;
  logic         key_err;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  mod_dec_invaddroundkey_seq #(.NR(14), .KEY_LAT(1)) dut (
    .clk(clk), .resetn(resetn), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .inp_addRK(inp_addRK), .key_addr(key_addr), .inp_key(inp_key),
`ifdef DEC_ADDRK_KEYPAR_EN
    .key_par(key_par), .key_err(key_err),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .outp_addRK(outp_addRK),
    .out_round(out_round), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] key_of(input logic [3:0] a);
    logic [3:0] d;
    d = a ^ 4'he;
    return 128'h000102030405060708090a0b0c0d0e0f ^ {16{4'h0, d}};
  endfunction

  // one-cycle registered ROM
  always @(posedge clk) inp_key <= key_of(key_addr);

`ifdef DEC_ADDRK_KEYPAR_EN
  always_comb
    for (int b = 0; b < 16; b++) key_par[b] = (^inp_key[8*b +: 8]) ^ par_flip[b];
`endif

  task automatic accept_block(input logic [127:0] d, input logic st);
    @(negedge clk);
    inp_addRK = d; in_valid = 1'b1; start = st;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; start = 1'b0;
  endtask

  task automatic wait_valid();
    for (int k = 0; k < 10 && out_valid !== 1'b1; k++) @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_chk++;
      if ({in_ready, out_valid, key_addr, outp_addRK} !== {1'b1, 1'b0, 4'd14, 128'd0})
        $display("FAIL reset_idle cyc %0d: in_ready=%b out_valid=%b key_addr=%0d outp=%h, want 1 0 14 0",
                 c, in_ready, out_valid, key_addr, outp_addRK);
      else n_pass++;
    end
  endtask

  task automatic test_first_block();
    logic [127:0] exp_d;
    exp_d = 128'h00102030405060708090a0b0c0d0e0f0;
    out_ready = 1'b0;
    accept_block(128'h00112233445566778899aabbccddeeff, 1'b1);
    n_chk++;
    if ({out_valid, in_ready, key_addr} !== {1'b0, 1'b0, 4'd14})
      $display("FAIL first_t0 out_valid=%b in_ready=%b key_addr=%0d, want 0 0 14", out_valid, in_ready, key_addr);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (out_valid !== 1'b0) $display("FAIL first_t1 out_valid=%b, want 0", out_valid);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({out_valid, outp_addRK, out_round, out_last} !== {1'b1, exp_d, 4'd14, 1'b0})
      $display("FAIL first_t2 out_valid=%b outp=%h round=%0d last=%b, want 1 %h 14 0",
               out_valid, outp_addRK, out_round, out_last, exp_d);
    else n_pass++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_chk++;
    if ({out_valid, in_ready, key_addr} !== {1'b0, 1'b1, 4'd13})
      $display("FAIL first_done out_valid=%b in_ready=%b key_addr=%0d, want 0 1 13", out_valid, in_ready, key_addr);
    else n_pass++;
  endtask

  task automatic test_sequence();
    logic [127:0] d;
    logic [3:0]   r;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_chk++;
    if (key_addr !== 4'd14) $display("FAIL seq_start key_addr=%0d, want 14", key_addr);
    else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      d = {4{32'hc0de0000 + 32'(i)}};
      r = (i == 15) ? 4'd14 : 4'(14 - i);
      accept_block(d, 1'b0);
      wait_valid();
      n_chk++;
      if ({out_valid, out_round, out_last, outp_addRK} !== {1'b1, r, (r == 4'd0), d ^ key_of(r)})
        $display("FAIL seq_blk%0d valid=%b round=%0d last=%b outp=%h, want 1 %0d %b %h",
                 i, out_valid, out_round, out_last, outp_addRK, r, (r == 4'd0), d ^ key_of(r));
      else n_pass++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    n_chk++;
    if (key_addr !== 4'd13) $display("FAIL seq_wrap key_addr=%0d, want 13", key_addr);
    else n_pass++;
  endtask

  task automatic test_hold();
    logic [127:0] d;
    d = 128'hfedcba98765432100123456789abcdef;
    out_ready = 1'b0;
    accept_block(d, 1'b0);
    wait_valid();
    for (int c = 0; c < 5; c++) begin
      n_chk++;
      if ({out_valid, in_ready, out_round, outp_addRK} !== {1'b1, 1'b0, 4'd13, d ^ key_of(4'd13)})
        $display("FAIL hold_cyc%0d valid=%b in_ready=%b round=%0d outp=%h, want 1 0 13 %h",
                 c, out_valid, in_ready, out_round, outp_addRK, d ^ key_of(4'd13));
      else n_pass++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_chk++;
    if ({out_valid, in_ready, key_addr} !== {1'b0, 1'b1, 4'd12})
      $display("FAIL hold_release valid=%b in_ready=%b key_addr=%0d, want 0 1 12", out_valid, in_ready, key_addr);
    else n_pass++;
  endtask

  task automatic test_reset_fetch();
    logic [127:0] d;
    logic         seen;
    d = 128'h0f0e0d0c0b0a09080706050403020100;
    out_ready = 1'b1;
    accept_block(d, 1'b0);
    resetn = 1'b0;
    #1;
    n_chk++;
    if ({out_valid, key_addr, outp_addRK, out_round, out_last} !== {1'b0, 4'd14, 128'd0, 4'd0, 1'b0})
      $display("FAIL rst_fetch_now valid=%b key_addr=%0d outp=%h round=%0d last=%b, want 0 14 0 0 0",
               out_valid, key_addr, outp_addRK, out_round, out_last);
    else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_chk++;
    if (seen !== 1'b0 || in_ready !== 1'b1) $display("FAIL rst_fetch_quiet saw_valid=%b in_ready=%b, want 0 1", seen, in_ready);
    else n_pass++;
    accept_block(d, 1'b0);
    wait_valid();
    n_chk++;
    if ({out_valid, out_round, outp_addRK} !== {1'b1, 4'd14, d ^ key_of(4'd14)})
      $display("FAIL rst_fetch_next valid=%b round=%0d outp=%h, want 1 14 %h",
               out_valid, out_round, outp_addRK, d ^ key_of(4'd14));
    else n_pass++;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

`ifdef DEC_ADDRK_KEYPAR_EN
  task automatic test_keypar();
    logic [127:0] d;
    d = 128'h55aa55aa55aa55aa55aa55aa55aa55aa;
    out_ready = 1'b1;
    n_chk++;
    if (key_err !== 1'b0) $display("FAIL par_init key_err=%b, want 0", key_err);
    else n_pass++;
    par_flip = 16'h0008;
    accept_block(d, 1'b0);
    wait_valid();
    n_chk++;
    if ({key_err, out_round, outp_addRK} !== {1'b1, 4'd13, d ^ key_of(4'd13)})
      $display("FAIL par_bad key_err=%b round=%0d outp=%h, want 1 13 %h", key_err, out_round, outp_addRK, d ^ key_of(4'd13));
    else n_pass++;
    @(negedge clk);
    par_flip = 16'h0000;
    accept_block(d, 1'b0);
    wait_valid();
    n_chk++;
    if ({key_err, out_round} !== {1'b1, 4'd12}) $display("FAIL par_sticky key_err=%b round=%0d, want 1 12", key_err, out_round);
    else n_pass++;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_chk++;
    if (key_err !== 1'b0) $display("FAIL par_clear key_err=%b, want 0", key_err);
    else n_pass++;
  endtask
`endif

  initial begin
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inp_addRK = '0; resetn = 1'b0;
`ifdef DEC_ADDRK_KEYPAR_EN
    par_flip = '0;
`endif
    test_reset();
    test_first_block();
    test_sequence();
    test_hold();
    test_reset_fetch();
`ifdef DEC_ADDRK_KEYPAR_EN
    test_keypar();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
